// File: rtl/key_loader_pkg.sv
// key_loader_pkg
// Shared constants for the key loader: default geometry, word-counter
// width helper and the FSM state encodings.
package key_loader_pkg;

  localparam int KEY_WIDTH_DEF  = 32;
  localparam int WORD_WIDTH_DEF = 8;
  localparam int WORDS          = KEY_WIDTH_DEF / WORD_WIDTH_DEF;
  localparam int CNT_W          = $clog2(WORDS + 1);

  // State | meaning
  // IDLE    | waiting for load_start, decoy on key_out
  // LOAD    | accepting data beats then the checksum beat
  // CHECK   | one cycle, compare checksum with accumulator
  // ARMED   | verified key on key_out, terminal until reset
  // FAIL    | checksum mismatch, decoy on key_out, retry allowed
  // LOCKOUT | retry budget exhausted, terminal until reset
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_CHECK   = 3'd2;
  localparam logic [2:0] ST_ARMED   = 3'd3;
  localparam logic [2:0] ST_FAIL    = 3'd4;
  localparam logic [2:0] ST_LOCKOUT = 3'd5;

  // Counter must reach WORDS (the checksum slot), hence words+1 codes.
  function automatic int cnt_width(input int words);
    return $clog2(words + 1);
  endfunction

endpackage

// File: rtl/key_loader_accum.sv
// key_word_accum
// Shadow register that collects the key one word at a time plus the
// running XOR of all words written.
// Ports:
//   clk, rst  - clock, async active-high reset
//   clr       - zero shadow and accumulator (priority over load_en)
//   load_en   - write data into word slot idx and fold it into acc
//   idx       - word slot, 0 = least significant word
//   data      - word payload
//   shadow    - collected key (never exposed directly downstream)
//   acc       - XOR of all words written since the last clear
module key_word_accum
  import key_loader_pkg::*;
#(
  parameter int KEY_WIDTH  = KEY_WIDTH_DEF,
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int CW         = CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  load_en,
  input  logic [CW-1:0]         idx,
  input  logic [WORD_WIDTH-1:0] data,
  output logic [KEY_WIDTH-1:0]  shadow,
  output logic [WORD_WIDTH-1:0] acc
);

  localparam int N_WORDS = KEY_WIDTH / WORD_WIDTH;

  logic [KEY_WIDTH-1:0]  shadow_q, shadow_d;
  logic [WORD_WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    shadow_d = shadow_q;
    acc_d    = acc_q;
    if (clr) begin
      shadow_d = '0;
      acc_d    = '0;
    end else if (load_en) begin
      for (int k = 0; k < N_WORDS; k++) begin
        if (int'(idx) == k) shadow_d[k*WORD_WIDTH +: WORD_WIDTH] = data;
      end
      acc_d = acc_q ^ data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      acc_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      acc_q    <= acc_d;
    end
  end

  assign shadow = shadow_q;
  assign acc    = acc_q;

endmodule

// File: rtl/key_loader.sv
// key_loader
// Receives an unlock key as byte beats on a valid/ready stream, verifies
// an XOR checksum beat and only then drives the key to the locked netlist.
// A decoy value is driven at all other times; MAX_RETRY bad checksums
// lock the block until reset.
// Ports:
//   clk, rst    - clock, async active-high reset
//   load_start  - one-cycle request to start (or retry) a load
//   s_valid, s_data, s_ready - key stream, beat = s_valid && s_ready
//   key_out     - key bus, bit i drives keyIn_0_i
//   key_valid   - key_out holds the verified key
//   busy        - loading or checking
//   err         - last attempt failed its checksum
//   lockout     - refused until reset
//   retry_cnt   - failed attempts so far
module key_loader
  import key_loader_pkg::*;
#(
  parameter int                   KEY_WIDTH  = KEY_WIDTH_DEF,
  parameter int                   WORD_WIDTH = WORD_WIDTH_DEF,
  parameter logic [KEY_WIDTH-1:0] DECOY      = '0,
  parameter int                   MAX_RETRY  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  s_valid,
  input  logic [WORD_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [KEY_WIDTH-1:0]  key_out,
  output logic                  key_valid,
  output logic                  busy,
  output logic                  err,
  output logic                  lockout,
  output logic [2:0]            retry_cnt
);

  localparam int N_WORDS = KEY_WIDTH / WORD_WIDTH;
  localparam int CW      = cnt_width(N_WORDS);

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] csum_q, csum_d;
  logic [KEY_WIDTH-1:0]  key_q, key_d;
  logic                  key_valid_q, key_valid_d;
  logic                  err_q, err_d;
  logic [2:0]            retry_q, retry_d;

  logic                  clr, load_en, beat;
  logic [2:0]            retry_inc;
  logic [KEY_WIDTH-1:0]  shadow;
  logic [WORD_WIDTH-1:0] acc;

  assign beat      = s_valid && (state_q == ST_LOAD);
  assign retry_inc = retry_q + 3'd1;

  key_word_accum #(
    .KEY_WIDTH (KEY_WIDTH),
    .WORD_WIDTH(WORD_WIDTH),
    .CW        (CW)
  ) u_accum (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .load_en(load_en),
    .idx    (cnt_q),
    .data   (s_data),
    .shadow (shadow),
    .acc    (acc)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    err_d       = err_q;
    retry_d     = retry_q;
    clr         = 1'b0;
    load_en     = 1'b0;

    case (state_q)
      ST_IDLE, ST_FAIL: begin
        if (load_start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          clr     = 1'b1;
        end
      end
      ST_LOAD: begin
        if (beat) begin
          if (cnt_q == CW'(N_WORDS)) begin
            csum_d  = s_data;
            state_d = ST_CHECK;
          end else begin
            load_en = 1'b1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      ST_CHECK: begin
        if (csum_q == acc) begin
          // Only path by which the shadow register reaches key_out.
          state_d     = ST_ARMED;
          key_d       = shadow;
          key_valid_d = 1'b1;
          err_d       = 1'b0;
        end else begin
          retry_d = retry_inc;
          err_d   = 1'b1;
          state_d = (retry_inc == 3'(MAX_RETRY)) ? ST_LOCKOUT : ST_FAIL;
        end
      end
      ST_ARMED:   state_d = ST_ARMED;
      ST_LOCKOUT: state_d = ST_LOCKOUT;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      csum_q      <= '0;
      key_q       <= DECOY;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
      retry_q     <= 3'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      csum_q      <= csum_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      err_q       <= err_d;
      retry_q     <= retry_d;
    end
  end

  assign s_ready   = (state_q == ST_LOAD);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign lockout   = (state_q == ST_LOCKOUT);
  assign key_out   = key_q;
  assign key_valid = key_valid_q;
  assign err       = err_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_key_loader.sv
module tb_key_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready;
  logic [31:0] key_out;
  logic        key_valid, busy, err, lockout;
  logic [2:0]  retry_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  key_loader dut (
    .clk       (clk),
    .rst       (rst),
    .load_start(load_start),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .key_out   (key_out),
    .key_valid (key_valid),
    .busy      (busy),
    .err       (err),
    .lockout   (lockout),
    .retry_cnt (retry_cnt)
  );

  always #5 clk = ~clk;

  // Transaction-level reference model.
  bit          m_armed, m_locked, m_err;
  int          m_retry;
  logic [31:0] m_key;

  function automatic logic [7:0] xsum(input logic [31:0] k);
    return k[7:0] ^ k[15:8] ^ k[23:16] ^ k[31:24];
  endfunction

  function automatic void model_reset();
    m_armed = 0; m_locked = 0; m_err = 0; m_retry = 0; m_key = 32'h0;
  endfunction

  function automatic void model_attempt(input logic [31:0] k, input logic [7:0] c);
    if (m_armed || m_locked) return;
    if (xsum(k) == c) begin
      m_armed = 1; m_key = k; m_err = 0;
    end else begin
      m_retry++; m_err = 1;
      if (m_retry == 3) m_locked = 1;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic [31:0] e_key,
                                    input bit e_valid, input bit e_err,
                                    input logic [2:0] e_retry, input bit e_lock);
    check({tag, ".key_out"},   key_out,   e_key);
    check({tag, ".key_valid"}, {31'b0, key_valid}, {31'b0, e_valid});
    check({tag, ".err"},       {31'b0, err},       {31'b0, e_err});
    check({tag, ".retry_cnt"}, {29'b0, retry_cnt}, {29'b0, e_retry});
    check({tag, ".lockout"},   {31'b0, lockout},   {31'b0, e_lock});
    check({tag, ".busy"},      {31'b0, busy},      32'd0);
    check({tag, ".s_ready"},   {31'b0, s_ready},   32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; load_start = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Full attempt: load_start (with a stray s_valid in the same cycle), then
  // 4 data beats and the checksum beat with random gaps. Leaves the bench
  // at the negedge after the CHECK->outcome edge.
  task automatic do_load(input string tag, input logic [31:0] k, input logic [7:0] c,
                         input int max_gap, input bit exp_acc);
    logic [7:0] beats [5];
    bit acc;
    int wait_cnt;
    beats[0] = k[7:0]; beats[1] = k[15:8]; beats[2] = k[23:16]; beats[3] = k[31:24];
    beats[4] = c;
    acc = 1;
    @(negedge clk);
    load_start = 1'b1; s_valid = 1'b1; s_data = 8'($urandom);
    @(negedge clk);
    load_start = 1'b0;
    for (int b = 0; b < 5 && acc; b++) begin
      int gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gaps; g++) begin
        s_valid = 1'b0; s_data = 8'($urandom);
        @(negedge clk);
      end
      s_valid = 1'b1; s_data = beats[b];
      wait_cnt = 0;
      while (!s_ready && wait_cnt < 6) begin
        @(negedge clk);
        wait_cnt++;
      end
      if (!s_ready) acc = 0;
      else @(negedge clk);
    end
    s_valid = 1'b0; s_data = 8'($urandom);
    check({tag, ".accepted"}, {31'b0, acc}, {31'b0, exp_acc});
    if (acc) begin
      check({tag, ".check_busy"},      {31'b0, busy},      32'd1);
      check({tag, ".check_key_valid"}, {31'b0, key_valid}, 32'd0);
      check({tag, ".check_key_out"},   key_out,            32'h0);
    end
    @(negedge clk);
  endtask

  typedef struct {
    bit          rst_before;
    logic [31:0] key;
    logic [7:0]  csum;
    int          gap;
    logic [31:0] e_key;
    bit          e_valid;
    bit          e_err;
    logic [2:0]  e_retry;
    bit          e_lock;
    bit          e_acc;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{1, 32'hDEADBEEF, 8'h22, 0, 32'hDEADBEEF, 1, 0, 3'd0, 0, 1};
    vecs[1] = '{1, 32'hDEADBEEF, 8'h22, 5, 32'hDEADBEEF, 1, 0, 3'd0, 0, 1};
    vecs[2] = '{1, 32'hDEADBEEF, 8'h23, 0, 32'h0,        0, 1, 3'd1, 0, 1};
    vecs[3] = '{0, 32'hDEADBEEF, 8'h22, 2, 32'hDEADBEEF, 1, 0, 3'd1, 0, 1};
    vecs[4] = '{1, 32'h12345678, 8'h00, 0, 32'h0,        0, 1, 3'd1, 0, 1};
    vecs[5] = '{0, 32'h12345678, 8'h01, 3, 32'h0,        0, 1, 3'd2, 0, 1};
    vecs[6] = '{0, 32'hDEADBEEF, 8'h00, 0, 32'h0,        0, 1, 3'd3, 1, 1};
    vecs[7] = '{0, 32'hDEADBEEF, 8'h22, 0, 32'h0,        0, 1, 3'd3, 1, 0};
    vecs[8] = '{1, 32'hDEADBEEF, 8'h22, 0, 32'hDEADBEEF, 1, 0, 3'd0, 0, 1};
    vecs[9] = '{0, 32'h00000000, 8'h00, 0, 32'hDEADBEEF, 1, 0, 3'd0, 0, 0};

    // Reset values, including async assertion without a clock edge.
    #2;
    check_idle_outputs("reset", 32'h0, 0, 0, 3'd0, 0);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      if (vecs[i].rst_before) do_reset();
      do_load(tag, vecs[i].key, vecs[i].csum, vecs[i].gap, vecs[i].e_acc);
      check_idle_outputs(tag, vecs[i].e_key, vecs[i].e_valid, vecs[i].e_err,
                         vecs[i].e_retry, vecs[i].e_lock);
    end

    // Reset mid-load after two beats: partial key never exposed.
    do_reset();
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0; s_valid = 1'b1; s_data = 8'hEF;
    @(negedge clk); s_data = 8'hBE;
    @(negedge clk); s_valid = 1'b0;
    check("midload.busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_idle_outputs("midload_rst", 32'h0, 0, 0, 3'd0, 0);
    @(negedge clk); rst = 1'b0;
    model_reset();
    do_load("after_rst", 32'hDEADBEEF, 8'h22, 1, 1);
    check_idle_outputs("after_rst", 32'hDEADBEEF, 1, 0, 3'd0, 0);

    // Randomized attempts against the reference model.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      logic [31:0] k;
      logic [7:0]  c;
      string tag;
      tag = $sformatf("rnd%0d", i);
      if ($urandom_range(0, 5) == 0) do_reset();
      k = $urandom;
      c = xsum(k);
      if ($urandom_range(0, 1) == 1) c = c ^ 8'($urandom_range(1, 255));
      do_load(tag, k, c, 5, !(m_armed || m_locked));
      model_attempt(k, c);
      check_idle_outputs(tag, m_armed ? m_key : 32'h0, m_armed, m_err,
                         3'(m_retry), m_locked);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
